// File: rtl/col_fdct.sv
// col_fdct: 8-point 1-D forward DCT column stage.
// Loads eight signed samples one per handshake. It then computes one
// coefficient per cycle for eight cycles and presents all eight coefficients
// in parallel until downstream accepts them.
// Optional build macro: FDCT_SAT_EN. When defined, each coefficient saturates
// to the OUT_W signed range. Otherwise the coefficient wraps to its low
// OUT_W bits.
module col_fdct #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*OUT_W-1:0]      out_coef
);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]               r_state;
    logic [2:0]               r_cnt;
    logic [2:0]               r_k;
    logic signed [IN_W-1:0]   r_x [8];
    logic                     r_outValid;
    logic [8*OUT_W-1:0]       r_coef;

    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_round;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [OUT_W-1:0]  w_y;

    // Cosine ROM.
    // C[k][n] = round(2048 * c_k * cos(m*pi/16)), where m = (2n+1)*k.
    // The phase m is folded into the first quadrant, and the sign is applied
    // afterwards. This keeps the table at nine magnitudes.
    function automatic logic signed [12:0] fdctCoef(input logic [2:0] k, input logic [2:0] n);
        logic [6:0]        prod;
        logic [4:0]        m;
        logic [3:0]        a;
        logic              neg;
        logic signed [12:0] mag;
        prod = {3'b000, n, 1'b1} * {4'b0000, k};
        m    = prod[4:0];
        if (m > 5'd16) begin
            m = 5'd0 - m;
        end
        neg = (m > 5'd8);
        a   = neg ? 4'(5'd16 - m) : m[3:0];
        case (a)
            4'd0:    mag = 13'sd2048;
            4'd1:    mag = 13'sd2009;
            4'd2:    mag = 13'sd1892;
            4'd3:    mag = 13'sd1703;
            4'd4:    mag = 13'sd1448;
            4'd5:    mag = 13'sd1138;
            4'd6:    mag = 13'sd784;
            4'd7:    mag = 13'sd400;
            default: mag = 13'sd0;
        endcase
        if (k == 3'd0) begin
            mag = 13'sd1448;
        end
        return neg ? -mag : mag;
    endfunction

    // Coefficient k datapath.
    // Eight parallel products are summed at full accumulator width.
    // The sum is rounded, then arithmetically shifted down by 12.
    always_comb begin
        w_acc = '0;
        for (int n = 0; n < 8; n++) begin
            w_acc = w_acc + ACC_W'(r_x[n]) * ACC_W'(fdctCoef(r_k, 3'(n)));
        end
        w_round = w_acc + ACC_W'(2048);
        w_shift = w_round >>> 12;
    end

`ifdef FDCT_SAT_EN
    localparam longint MAX_Y = (longint'(1) <<< (OUT_W-1)) - 1;
    localparam longint MIN_Y = -(longint'(1) <<< (OUT_W-1));

    // Clamp the shifted value into the signed output range.
    always_comb begin
        if (longint'(w_shift) > MAX_Y) begin
            w_y = OUT_W'(MAX_Y);
        end else if (longint'(w_shift) < MIN_Y) begin
            w_y = OUT_W'(MIN_Y);
        end else begin
            w_y = OUT_W'(w_shift);
        end
    end
`else
    // Keep only the low OUT_W bits of the shifted value (two's-complement wrap).
    always_comb begin
        w_y = OUT_W'(w_shift);
    end
`endif

    // Control FSM.
    // LOAD gathers eight samples, COMPUTE walks k from 0 to 7, and DONE holds
    // the result until the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_cnt      <= 3'd0;
            r_k        <= 3'd0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= ST_COMPUTE;
                            r_k     <= 3'd0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_state    <= ST_DONE;
                        r_outValid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state    <= ST_LOAD;
                        r_cnt      <= 3'd0;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_cnt      <= 3'd0;
                    r_k        <= 3'd0;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // Sample capture into the eight-entry column buffer while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_x[i] <= '0;
            end
        end else if (r_state == ST_LOAD && in_valid) begin
            r_x[r_cnt] <= in_data;
        end
    end

    // Write coefficient k into its output slot, once per COMPUTE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_coef[r_k*OUT_W +: OUT_W] <= w_y;
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = r_outValid;
    assign out_coef  = r_coef;

endmodule

// File: tb/tb_col_fdct.sv
// tb_col_fdct: randomized self-checking bench for col_fdct.
// The reference model derives the DCT coefficients from real-valued cosines.
// It then applies the rounding shift and the output conversion with integer
// arithmetic. Build with FDCT_SAT_EN to check the saturating variant.
module tb_col_fdct;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int ACC_W = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*OUT_W-1:0]     out_coef;

    int compareCount;
    int mismatchCount;

    col_fdct #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint getCoef(input int k);
        logic signed [OUT_W-1:0] v;
        v = out_coef[k*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    // Reference coefficient computed directly from the cosine definition.
    // Rounding is half away from zero.
    function automatic longint refCoef(input int k, input int n);
        real c;
        real v;
        c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v = 2048.0 * c * $cos((2.0 * n + 1.0) * k * 3.14159265358979323846 / 16.0);
        if (v >= 0.0) return longint'($floor(v + 0.5));
        else          return -longint'($floor(-v + 0.5));
    endfunction

    // Reference output for coefficient k of column x.
    function automatic longint refY(input int x[8], input int k);
        longint acc;
        longint s;
        longint lim;
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(x[n]) * refCoef(k, n);
        s   = (acc + 2048) >>> 12;
        lim = longint'(1) << (OUT_W - 1);
`ifdef FDCT_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim)    s = -lim;
`else
        s = s & ((lim << 1) - 1);
        if (s >= lim) s = s - (lim << 1);
`endif
        return s;
    endfunction

    // Drive one sample and wait (bounded) for it to be accepted.
    // Called at a falling edge; returns at the falling edge after capture.
    task automatic sendSample(input int v);
        int waitCnt;
        waitCnt  = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) checkOutput("inReadyTimeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
    endtask

    // Feed a whole column, optionally with random idle gaps between samples.
    task automatic applyStimulus(input int x[8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int j = 0; j < idle; j++) @(negedge clk);
            end
            sendSample(x[i]);
        end
    endtask

    // Check latency, results, hold behaviour under backpressure, and the
    // output handshake. Entered at the falling edge after the last capture.
    task automatic runColumn(input string tag, input int x[8], input bit gaps, input int holdCycles);
        logic [8*OUT_W-1:0] snap;
        applyStimulus(x, gaps);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 7) begin
                checkOutput({tag, ".validEarly"}, longint'(out_valid), 0);
                checkOutput({tag, ".readyInCompute"}, longint'(in_ready), 0);
            end
            if (c == 8) checkOutput({tag, ".validAt8"}, longint'(out_valid), 1);
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s.y%0d", tag, k), getCoef(k), refY(x, k));
        end
        snap = out_coef;
        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'($urandom);
            in_data  = IN_W'($urandom);
            @(negedge clk);
            checkOutput({tag, ".holdStable"}, longint'(out_coef == snap), 1);
            checkOutput({tag, ".holdReady"}, longint'(in_ready), 0);
            checkOutput({tag, ".holdValid"}, longint'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".validDrop"}, longint'(out_valid), 0);
        checkOutput({tag, ".readyRise"}, longint'(in_ready), 1);
    endtask

    int col[8];

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("resetReady", longint'(in_ready), 1);
        checkOutput("resetValid", longint'(out_valid), 0);
        checkOutput("resetCoef", longint'(out_coef == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: DC column.
        for (int i = 0; i < 8; i++) col[i] = 100;
        runColumn("dcPos", col, 1'b0, 0);
        checkOutput("dcPos.y0const", getCoef(0), 283);

        // T2: negative DC column.
        for (int i = 0; i < 8; i++) col[i] = -100;
        runColumn("dcNeg", col, 1'b0, 0);
        checkOutput("dcNeg.y0const", getCoef(0), -283);

        // T3: impulse column.
        for (int i = 0; i < 8; i++) col[i] = 0;
        col[0] = 4096;
        runColumn("impulse", col, 1'b0, 0);
        checkOutput("impulse.y1const", getCoef(1), 2009);
        checkOutput("impulse.y2const", getCoef(2), 1892);

        // T4: full-scale column overflows y[0].
        for (int i = 0; i < 8; i++) col[i] = 32767;
        runColumn("overflow", col, 1'b0, 0);
`ifdef FDCT_SAT_EN
        checkOutput("overflow.y0const", getCoef(0), 32767);
`else
        checkOutput("overflow.y0const", getCoef(0), 27133);
`endif

        // T5: backpressure for five cycles, with in_valid pulses that must be ignored.
        for (int i = 0; i < 8; i++) col[i] = int'($signed(IN_W'($urandom)));
        runColumn("backpressure", col, 1'b1, 5);

        // T6: reset partway through a load.
        for (int i = 0; i < 3; i++) sendSample(500);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(500);
            @(negedge clk);
            checkOutput("midReset.valid", longint'(out_valid), 0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) col[i] = 100;
        runColumn("afterReset", col, 1'b0, 0);
        checkOutput("afterReset.y0const", getCoef(0), 283);

        // Random columns, some with extreme samples, gaps, and short backpressure.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       col[i] = 32767;
                    1:       col[i] = -32768;
                    default: col[i] = int'($signed(IN_W'($urandom)));
                endcase
            end
            runColumn($sformatf("rand%0d", t), col, 1'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
